midi_event_parser: RTL

Parametrised successor to the synthesizer's fixed UART/CPU MIDI front end. Takes raw MIDI byte streams from NUM_SRC sources (UART, CPU port, future USB), each with its own parser state. Handles running status, channel filtering and note-on-velocity-0 folding. Completed channel-voice events are written into a FIFO that feeds the note stack and controller logic through a valid/ready handshake.

---
 rtl/midi_pkg.sv | 47 ++++
 rtl/midi_event_parser_if.sv | 31 +++
 rtl/midi_event_fifo.sv | 57 +++++
 rtl/midi_event_parser.sv | 114 +++++++++++
 4 files changed

// File: rtl/midi_pkg.sv
// Shared MIDI definitions: event types, status nibbles, byte-class thresholds
// and the packed event word carried through the event FIFO.
package midi_pkg;

   localparam logic [3:0] ST_NOTE_OFF = 4'h8;
   localparam logic [3:0] ST_NOTE_ON  = 4'h9;
   localparam logic [3:0] ST_POLY_AT  = 4'hA;
   localparam logic [3:0] ST_CTRL     = 4'hB;
   localparam logic [3:0] ST_PRG      = 4'hC;
   localparam logic [3:0] ST_CHAN_AT  = 4'hD;
   localparam logic [3:0] ST_PITCH    = 4'hE;

   localparam logic [7:0] SYS_MIN = 8'hF0;
   localparam logic [7:0] RT_MIN  = 8'hF8;

   // Room for up to 16 sources; the top level exposes only SRC_W bits.
   localparam int EV_SRC_W = 4;

   typedef enum logic [2:0] {
      EV_NOTE_OFF = 3'd0,
      EV_NOTE_ON  = 3'd1,
      EV_POLY_AT  = 3'd2,
      EV_CTRL     = 3'd3,
      EV_PRG      = 3'd4,
      EV_CHAN_AT  = 3'd5,
      EV_PITCH    = 3'd6
   } ev_type_e;

   typedef struct packed {
      ev_type_e            typ;
      logic [3:0]          ch;
      logic [EV_SRC_W-1:0] src;
      logic [6:0]          d0;
      logic [6:0]          d1;
   } midi_ev_t;

   function automatic logic two_data_bytes(input logic [3:0] nib);
      return !(nib == ST_PRG || nib == ST_CHAN_AT);
   endfunction

   // Note-on with zero velocity is folded into a note-off.
   function automatic ev_type_e nib_to_type(input logic [3:0] nib, input logic [6:0] d1);
      if (nib == ST_NOTE_ON && d1 == 7'd0) return EV_NOTE_OFF;
      return ev_type_e'(3'(nib - ST_NOTE_OFF));
   endfunction

endpackage

// File: rtl/midi_event_parser_if.sv
// Byte-input and event-output bus of the MIDI event parser.
interface midi_event_parser_if #(
   parameter int NUM_SRC = 2,
   parameter int SRC_W   = 1,
   parameter int FIFO_AW = 3
);
   logic [NUM_SRC-1:0]   in_valid;
   logic [8*NUM_SRC-1:0] in_data;
   logic [NUM_SRC-1:0]   in_ready;
   logic [15:0]          ch_mask;
   logic                 omni;
   logic                 ev_valid;
   logic                 ev_ready;
   logic [2:0]           ev_type;
   logic [3:0]           ev_ch;
   logic [SRC_W-1:0]     ev_src;
   logic [6:0]           ev_d0;
   logic [6:0]           ev_d1;
   logic [FIFO_AW:0]     fifo_level;
   logic [7:0]           drop_cnt;

   modport master (
      output in_valid, in_data, ch_mask, omni, ev_ready,
      input  in_ready, ev_valid, ev_type, ev_ch, ev_src, ev_d0, ev_d1, fifo_level, drop_cnt
   );

   modport slave (
      input  in_valid, in_data, ch_mask, omni, ev_ready,
      output in_ready, ev_valid, ev_type, ev_ch, ev_src, ev_d0, ev_d1, fifo_level, drop_cnt
   );
endinterface

// File: rtl/midi_event_fifo.sv
// First-word-fall-through event FIFO with occupancy level and a saturating
// counter of events dropped because the FIFO was full.
module midi_event_fifo
   import midi_pkg::*;
#(
   parameter int DEPTH = 8,
   parameter int AW    = 3
) (
   input  logic          clk_i,
   input  logic          rst_ni,
   input  logic          push_i,
   input  midi_ev_t      push_data_i,
   input  logic          pop_i,
   output midi_ev_t      head_o,
   output logic          valid_o,
   output logic [AW:0]   level_o,
   output logic [7:0]    drop_cnt_o
);
   midi_ev_t      mem_q [DEPTH];
   logic [AW-1:0] wr_ptr_q, rd_ptr_q;
   logic [AW:0]   level_q, level_d;
   logic          valid_q;
   logic [7:0]    drop_q;
   logic          full, pop_en, wr_en, drop_ev;

   assign full    = (level_q == (AW+1)'(DEPTH));
   assign pop_en  = pop_i & valid_q;
   // A full FIFO still takes a push when the head leaves in the same cycle.
   assign wr_en   = push_i & (~full | pop_en);
   assign drop_ev = push_i & full & ~pop_en;
   assign level_d = level_q + (AW+1)'(wr_en) - (AW+1)'(pop_en);

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         level_q  <= '0;
         valid_q  <= 1'b0;
         drop_q   <= '0;
      end else begin
         if (wr_en)  wr_ptr_q <= wr_ptr_q + 1'b1;
         if (pop_en) rd_ptr_q <= rd_ptr_q + 1'b1;
         level_q <= level_d;
         valid_q <= (level_d != '0);
         if (drop_ev && drop_q != 8'hFF) drop_q <= drop_q + 8'd1;
      end
   end

   always_ff @(posedge clk_i) begin
      if (wr_en) mem_q[wr_ptr_q] <= push_data_i;
   end

   assign head_o     = mem_q[rd_ptr_q];
   assign valid_o    = valid_q;
   assign level_o    = level_q;
   assign drop_cnt_o = drop_q;
endmodule

// File: rtl/midi_event_parser.sv
// Multi-source MIDI byte parser: round-robin byte arbitration, per-source
// running-status parsing, channel filtering, and event FIFO output.
module midi_event_parser
   import midi_pkg::*;
#(
   parameter int NUM_SRC    = 2,
   parameter int SRC_W      = 1,
   parameter int FIFO_DEPTH = 8,
   parameter int FIFO_AW    = 3
) (
   input logic CLOCK_25,
   input logic reset_reg_N,
   midi_event_parser_if.slave bus
);
   logic [SRC_W-1:0]   ptr_q, gidx;
   logic [NUM_SRC-1:0] grant;
   logic               xfer;
   logic [7:0]         byte_c;

   logic [7:0]         rs_q [NUM_SRC];
   logic [6:0]         d0_q [NUM_SRC];
   logic [NUM_SRC-1:0] rs_vld_q, cnt_q;

   logic [7:0]         cur_st;
   logic               two, is_data, final_c, push;
   midi_ev_t           ev_c, head;
   logic [EV_SRC_W-1:0] unused_src;

   // Round-robin: first valid source at or after the priority pointer wins.
   always_comb begin
      int idx;
      grant = '0;
      gidx  = '0;
      xfer  = 1'b0;
      for (int k = 0; k < NUM_SRC; k++) begin
         idx = (int'(ptr_q) + k) % NUM_SRC;
         if (!xfer && bus.in_valid[idx]) begin
            xfer       = 1'b1;
            grant[idx] = 1'b1;
            gidx       = SRC_W'(idx);
         end
      end
   end

   assign bus.in_ready = grant;
   assign byte_c  = bus.in_data[{gidx, 3'b000} +: 8];
   assign cur_st  = rs_q[gidx];
   assign two     = two_data_bytes(cur_st[7:4]);
   assign is_data = xfer & ~byte_c[7] & rs_vld_q[gidx];
   assign final_c = is_data & (cnt_q[gidx] | ~two);

   always_comb begin
      ev_c     = '0;
      ev_c.ch  = cur_st[3:0];
      ev_c.src = EV_SRC_W'(gidx);
      ev_c.d0  = two ? d0_q[gidx] : byte_c[6:0];
      ev_c.d1  = two ? byte_c[6:0] : 7'd0;
      ev_c.typ = nib_to_type(cur_st[7:4], ev_c.d1);
   end

   assign push = final_c & (bus.omni | bus.ch_mask[ev_c.ch]);

   always_ff @(posedge CLOCK_25 or negedge reset_reg_N) begin
      if (!reset_reg_N) begin
         ptr_q    <= '0;
         rs_vld_q <= '0;
         cnt_q    <= '0;
         for (int i = 0; i < NUM_SRC; i++) begin
            rs_q[i] <= '0;
            d0_q[i] <= '0;
         end
      end else if (xfer) begin
         ptr_q <= (gidx == SRC_W'(NUM_SRC-1)) ? '0 : gidx + 1'b1;
         // Realtime bytes pass through without touching parser state.
         if (byte_c < RT_MIN) begin
            if (byte_c >= SYS_MIN) begin
               rs_vld_q[gidx] <= 1'b0;
               cnt_q[gidx]    <= 1'b0;
            end else if (byte_c[7]) begin
               rs_q[gidx]     <= byte_c;
               rs_vld_q[gidx] <= 1'b1;
               cnt_q[gidx]    <= 1'b0;
            end else if (final_c) begin
               cnt_q[gidx] <= 1'b0;
            end else if (is_data) begin
               d0_q[gidx]  <= byte_c[6:0];
               cnt_q[gidx] <= 1'b1;
            end
         end
      end
   end

   midi_event_fifo #(
      .DEPTH (FIFO_DEPTH),
      .AW    (FIFO_AW)
   ) u_fifo (
      .clk_i       (CLOCK_25),
      .rst_ni      (reset_reg_N),
      .push_i      (push),
      .push_data_i (ev_c),
      .pop_i       (bus.ev_ready),
      .head_o      (head),
      .valid_o     (bus.ev_valid),
      .level_o     (bus.fifo_level),
      .drop_cnt_o  (bus.drop_cnt)
   );

   assign bus.ev_type = head.typ;
   assign bus.ev_ch   = head.ch;
   assign bus.ev_src  = head.src[SRC_W-1:0];
   assign bus.ev_d0   = head.d0;
   assign bus.ev_d1   = head.d1;
   assign unused_src  = head.src;
endmodule
